pt_dt_scheduler: RTL and testbench

Time-multiplexed pattern-detection scheduler: shares a single serial pattern comparator among NCH independent bit-stream requesters. A round-robin arbiter grants one channel per cycle. The block restores that channel's saved context, evaluates the granted bit against the fixed pattern and writes the context back. It sits between the per-channel serial sources and the downstream event logic, and replaces NCH copies of the per-stream detector FSM.

---
 rtl/pt_dt_scheduler.sv | 109 ++++++++++
 tb/tb_pt_dt_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pt_dt_scheduler.sv
// Shared serial pattern detector: a round-robin arbiter picks one requesting
// bit stream per cycle and runs that channel's saved detector context.
module pt_dt_scheduler #(
  parameter int              NCH     = 4,
  parameter int              PLEN    = 5,
  parameter logic [PLEN-1:0] PATTERN = 5'b11011,
  parameter bit              OVERLAP = 1'b0,
  parameter int              CW      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NCH-1:0]           req_i,
  input  logic [NCH-1:0]           d_i,
  output logic [NCH-1:0]           gnt_o,
  input  logic                     clr_cnt_i,
  output logic                     match_o,
  output logic [$clog2(NCH)-1:0]   match_ch_o,
  output logic [NCH*CW-1:0]        match_cnt_o
);

  localparam int                CHW      = $clog2(NCH);
  localparam int                FW       = $clog2(PLEN);
  localparam logic [FW-1:0]     FILL_MAX = FW'(PLEN - 1);
  localparam logic [CHW-1:0]    LAST_CH  = CHW'(NCH - 1);

  logic [CHW-1:0]  r_ptr;
  logic [PLEN-2:0] r_hist [NCH];
  logic [FW-1:0]   r_fill [NCH];
  logic [CW-1:0]   r_cnt  [NCH];
  logic            r_match;
  logic [CHW-1:0]  r_match_ch;

  logic [NCH-1:0]  w_gnt;
  logic [CHW-1:0]  w_gnt_idx;
  logic            w_any;
  logic [PLEN-1:0] w_word;
  logic            w_hit;

  // Round-robin search starting at r_ptr; the first requester found wins.
  always_comb begin
    logic [CHW-1:0] sel;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    sel       = '0;
    for (int i = 0; i < NCH; i++) begin
      sel = CHW'((int'(r_ptr) + i) % NCH);
      if (!w_any && req_i[sel]) begin
        w_any      = 1'b1;
        w_gnt[sel] = 1'b1;
        w_gnt_idx  = sel;
      end
    end
  end

  assign w_word = {r_hist[w_gnt_idx], d_i[w_gnt_idx]};
  assign w_hit  = w_any && (r_fill[w_gnt_idx] == FILL_MAX) && (w_word == PATTERN);

  // Context of the granted channel only; all others hold their state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
      // NOTE: the context arrays are reset because a mid-stream reset must discard partial patterns.
      for (int n = 0; n < NCH; n++) begin
        r_hist[n] <= '0;
        r_fill[n] <= '0;
      end
    end else if (w_any) begin
      // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
      r_ptr <= (w_gnt_idx == LAST_CH) ? '0 : w_gnt_idx + 1'b1;
      if (w_hit && !OVERLAP) begin
        r_hist[w_gnt_idx] <= '0;
        r_fill[w_gnt_idx] <= '0;
      end else begin
        r_hist[w_gnt_idx] <= w_word[PLEN-2:0];
        if (r_fill[w_gnt_idx] != FILL_MAX) r_fill[w_gnt_idx] <= r_fill[w_gnt_idx] + 1'b1;
      end
    end
  end

  // Match pulse and saturating per-channel counters; clear beats a coincident hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_match    <= 1'b0;
      r_match_ch <= '0;
      for (int n = 0; n < NCH; n++) r_cnt[n] <= '0;
    end else begin
      r_match <= w_hit;
      if (w_hit) r_match_ch <= w_gnt_idx;
      for (int n = 0; n < NCH; n++) begin
        if (clr_cnt_i) begin
          r_cnt[n] <= '0;
        end else if (w_hit && (w_gnt_idx == CHW'(n)) && (r_cnt[n] != '1)) begin
          r_cnt[n] <= r_cnt[n] + 1'b1;
        end
      end
    end
  end

  assign gnt_o      = w_gnt;
  assign match_o    = r_match;
  assign match_ch_o = r_match_ch;

  for (genvar n = 0; n < NCH; n++) begin : g_cnt_out
    assign match_cnt_o[n*CW +: CW] = r_cnt[n];
  end

endmodule

// File: tb/tb_pt_dt_scheduler.sv
// Directed bench for pt_dt_scheduler: a non-overlapping and an overlapping
// instance share one stimulus stream; expected values are hand-derived.
module tb_pt_dt_scheduler;

  logic        clk_i     = 1'b0;
  logic        rst_ni    = 1'b0;
  logic [3:0]  req_i     = '0;
  logic [3:0]  d_i       = '0;
  logic        clr_cnt_i = 1'b0;

  logic [3:0]  gnt_o,       gnt_ov;
  logic        match_o,     match_ov;
  logic [1:0]  match_ch_o,  match_ch_ov;
  logic [31:0] match_cnt_o, match_cnt_ov;

  logic [3:0]  last_gnt, last_gnt_ov;
  int          n_checks = 0;
  int          n_fail   = 0;

  pt_dt_scheduler #(.NCH(4), .PLEN(5), .PATTERN(5'b11011), .OVERLAP(1'b0), .CW(8)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .d_i(d_i), .gnt_o(gnt_o),
    .clr_cnt_i(clr_cnt_i), .match_o(match_o), .match_ch_o(match_ch_o), .match_cnt_o(match_cnt_o)
  );

  pt_dt_scheduler #(.NCH(4), .PLEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1), .CW(8)) u_dut_ov (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .d_i(d_i), .gnt_o(gnt_ov),
    .clr_cnt_i(clr_cnt_i), .match_o(match_ov), .match_ch_o(match_ch_ov), .match_cnt_o(match_cnt_ov)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after a rising edge, capture the grant,
  // then return 1 time unit after the consuming edge.
  task automatic cyc(input logic [3:0] req, input logic [3:0] d, input logic clr);
    req_i     = req;
    d_i       = d;
    clr_cnt_i = clr;
    #1;
    last_gnt    = gnt_o;
    last_gnt_ov = gnt_ov;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    req_i     = '0;
    d_i       = '0;
    clr_cnt_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [4:0] pat;
    logic [7:0] s2;
    logic [4:0] a0, b2;
    logic [3:0] e2;
    int         n_m, n_mov, i0, i2;

    pat = 5'b11011;
    s2  = 8'b11011011;
    a0  = 5'b11011;
    b2  = 5'b10101;
    e2  = 4'b1011;

    // Reset state and single-channel detection on ch0
    do_reset();
    check("rst_match", match_o, 0);
    check("rst_match_ch", match_ch_o, 0);
    check("rst_cnt", match_cnt_o, 0);
    req_i = 4'b1111;
    #1;
    check("rst_gnt_prio", gnt_o, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0001, {3'b000, pat[4-k]}, 1'b0);
      check("t1_gnt", last_gnt, 4'b0001);
      check("t1_match", match_o, (k == 4));
    end
    check("t1_match_ch", match_ch_o, 0);
    check("t1_cnt", match_cnt_o, 32'h0000_0001);
    cyc(4'b0000, 4'b0000, 1'b0);
    check("t1_gnt_idle", last_gnt, 4'b0000);
    check("t1_pulse_end", match_o, 0);

    // Non-overlapping vs overlapping on ch1: 1,1,0,1,1,0,1,1
    do_reset();
    n_m   = 0;
    n_mov = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(4'b0010, {2'b00, s2[7-k], 1'b0}, 1'b0);
      n_m   += int'(match_o);
      n_mov += int'(match_ov);
      if (k == 7) begin
        check("t2_ov_match_bit8", match_ov, 1);
        check("t2_ov_match_ch", match_ch_ov, 1);
      end
    end
    check("t2_nonov_count", n_m, 1);
    check("t2_ov_count", n_mov, 2);
    check("t2_nonov_cnt", match_cnt_o, 32'h0000_0100);
    check("t2_ov_cnt", match_cnt_ov, 32'h0000_0200);

    // Round-robin fairness: all four channels request, each fed 1,1,0,1,1
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cyc(4'b1111, {4{pat[4 - c/4]}}, 1'b0);
      check("t3_gnt", last_gnt, 4'b0001 << (c % 4));
      check("t3_match", match_o, (c >= 16));
      if (c >= 16) check("t3_match_ch", match_ch_o, c - 16);
    end
    cyc(4'b0000, 4'b0000, 1'b0);
    check("t3_pulse_end", match_o, 0);
    check("t3_cnt", match_cnt_o, 32'h0101_0101);

    // Context isolation: ch0 sends 11011, ch2 sends 10101, interleaved
    do_reset();
    i0 = 0;
    i2 = 0;
    for (int c = 0; c < 10; c++) begin
      cyc(4'b0101, {1'b0, (i2 < 5) ? b2[4-i2] : 1'b0, 1'b0, (i0 < 5) ? a0[4-i0] : 1'b0}, 1'b0);
      check("t4_gnt", last_gnt, (c % 2 == 0) ? 4'b0001 : 4'b0100);
      check("t4_match", match_o, (c == 8));
      if (c == 8) check("t4_match_ch", match_ch_o, 0);
      if (c % 2 == 0) i0++;
      else            i2++;
    end
    check("t4_cnt", match_cnt_o, 32'h0000_0001);
    // ch2 history 0101 plus 1,0,1,1 completes 11011 only if it was kept intact
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0100, {1'b0, e2[3-k], 2'b00}, 1'b0);
      check("t4_ch2_match", match_o, (k == 3));
    end
    check("t4_ch2_match_ch", match_ch_o, 2);
    check("t4_ch2_cnt", match_cnt_o, 32'h0001_0001);

    // Saturation on ch3, then clear coincident with a hit
    do_reset();
    n_m = 0;
    repeat (260) begin
      for (int k = 0; k < 5; k++) begin
        cyc(4'b1000, {pat[4-k], 3'b000}, 1'b0);
        n_m += int'(match_o);
      end
    end
    check("t5_hits", n_m, 260);
    check("t5_sat", match_cnt_o, 32'hFF00_0000);
    for (int k = 0; k < 4; k++) cyc(4'b1000, {pat[4-k], 3'b000}, 1'b0);
    cyc(4'b1000, 4'b1000, 1'b1);
    check("t5_clr_match", match_o, 1);
    check("t5_clr_match_ch", match_ch_o, 3);
    check("t5_clr_cnt", match_cnt_o, 32'h0000_0000);
    cyc(4'b0000, 4'b0000, 1'b0);

    // Async reset mid-pattern: ch0 sends 1,1,0,1 then reset between edges
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0001, {3'b000, pat[4-k]}, 1'b0);
      check("t6_pre_match", match_o, 0);
    end
    rst_ni = 1'b0;
    req_i  = 4'b1111;
    d_i    = 4'b0001;
    #1;
    check("t6_ptr_reset", gnt_o, 4'b0001);
    check("t6_ptr_reset_ov", gnt_ov, 4'b0001);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("t6_no_match", match_o, 0);
    for (int k = 1; k < 5; k++) begin
      cyc(4'b0001, {3'b000, pat[4-k]}, 1'b0);
      check("t6_post_match", match_o, (k == 4));
    end
    check("t6_match_ch", match_ch_o, 0);
    check("t6_cnt", match_cnt_o, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
